// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer/checker for the encoder -> channel -> Viterbi loop.
// Burst injection is built only with VITERBI_FRAME_CTRL_ERRINJ_EN defined.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2,
  parameter int DEC_LAT   = 16,
  parameter int N         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] seed_i,
  input  logic        inj_en_i,
  input  logic        dec_d_i,
  output logic        enc_en_o,
  output logic        enc_d_o,
  output logic [1:0]  err_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o
);

  localparam int CW = $clog2(FRAME_LEN + DEC_LAT + 1);
  localparam logic [CW-1:0] PAY_END  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TAIL_END = CW'(FRAME_LEN + TAIL_LEN - 1);
  localparam logic [CW-1:0] DRN_END  = CW'(FRAME_LEN + DEC_LAT - 1);
  localparam logic [CW-1:0] WIN_LO   = CW'(DEC_LAT);
  localparam logic [CW-1:0] WIN_HI   = CW'(DEC_LAT + FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    TAIL,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [15:0] lfsr, lfsr_n;
  logic inj_en, inj_en_n;
  logic start_ok;
  logic [DEC_LAT-1:0] dly;
  logic in_win, mis;
  logic enc_on_n, burst_n;

  // Next-state, frame counter and LFSR advance
  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    lfsr_n   = lfsr;
    inj_en_n = inj_en;
    start_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_n  = PAYLOAD;
          cyc_n    = '0;
          lfsr_n   = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
          inj_en_n = inj_en_i;
        end
      end
      PAYLOAD: begin
        cyc_n  = cyc + 1'b1;
        lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        if (cyc == PAY_END)
          state_n = (TAIL_LEN == 0) ? DRAIN : TAIL;
      end
      TAIL: begin
        cyc_n = cyc + 1'b1;
        if (cyc == TAIL_END)
          state_n = DRAIN;
      end
      DRAIN: begin
        cyc_n = cyc + 1'b1;
        if (cyc == DRN_END)
          state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign enc_on_n = (state_n == PAYLOAD) || (state_n == TAIL);
  assign burst_n  = (cyc_n[N-1:1] == '0);
  assign in_win   = (cyc >= WIN_LO) && (cyc < WIN_HI);
  assign mis      = busy_o && in_win && (dec_d_i != dly[DEC_LAT-1]);

  // State and registered encoder/status outputs, built from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cyc      <= '0;
      lfsr     <= '0;
      inj_en   <= 1'b0;
      enc_en_o <= 1'b0;
      enc_d_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      lfsr     <= lfsr_n;
      inj_en   <= inj_en_n;
      enc_en_o <= enc_on_n;
      enc_d_o  <= (state_n == PAYLOAD) && lfsr_n[0];
      busy_o   <= (state_n != IDLE);
      done_o   <= (state_n == DONE);
    end
  end

  // Reference copy of the encoder input, aligned to decoder latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dly <= '0;
    else if (busy_o)
      dly <= {dly[DEC_LAT-2:0], enc_d_o};
  end

  // Saturating payload mismatch counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bit_err_ct_o <= '0;
    else if (start_ok)
      bit_err_ct_o <= '0;
    else if (mis && (bit_err_ct_o != 16'hFFFF))
      bit_err_ct_o <= bit_err_ct_o + 1'b1;
  end

`ifdef VITERBI_FRAME_CTRL_ERRINJ_EN
  // Burst mask on bit[1] for the first two cycles of every 2^N window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_mask_o <= 2'b00;
      inj_ct_o   <= '0;
    end else begin
      err_mask_o <= (enc_on_n && inj_en_n && burst_n) ? 2'b10 : 2'b00;
      if (start_ok)
        inj_ct_o <= '0;
      else if ((err_mask_o != 2'b00) && (inj_ct_o != 16'hFFFF))
        inj_ct_o <= inj_ct_o + 1'b1;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = inj_en_n ^ burst_n;
  assign err_mask_o = 2'b00;
  assign inj_ct_o   = 16'h0000;
`endif

endmodule
